// File: rtl/motor_cmd_guard.sv
// -----------------------------------------------------------------------------
// motor_cmd_guard
//
// Safety stage between the SPI frame receiver and the four ESC pulse
// generators. Accepts a 32-bit throttle frame {front, left, right, back} once
// per rising edge of the receiver's frame-complete level. The frame is only
// passed on after an arming sequence of all-zero frames. If no frame arrives
// for TIMEOUT_CYCLES clocks, the block drops into a zero-throttle failsafe.
//
// Optional feature macro: MOTOR_CMD_SLEW_EN
//   defined   : in ARMED each byte rises by at most 1 per slew tick
//               (a tick occurs every SLEW_DIV clocks); decreases stay immediate.
//   undefined : no slew counter; motor_cmd follows the targets one cycle later.
//
// Parameters
//   TIMEOUT_CYCLES : clk cycles without an accepted frame before expiry
//   ARM_FRAMES     : consecutive zero frames needed to arm (1..255)
//   SLEW_DIV       : clk cycles per slew tick
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-low reset, clears all state
//   frame_done in   receiver frame-complete level (asynchronous to clk)
//   frame_data in   [31:0] {front, left, right, back}, stable while frame_done high
//   motor_cmd  out  [31:0] guarded commands, same byte order
//   armed      out  high in ARMED
//   failsafe   out  high in FAILSAFE
//   state      out  [1:0] DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3
// -----------------------------------------------------------------------------
module motor_cmd_guard #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd4_000_000,
  parameter int unsigned ARM_FRAMES     = 8,
  parameter int unsigned SLEW_DIV       = 32'd40_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_done,
  input  logic [31:0] frame_data,
  output logic [31:0] motor_cmd,
  output logic        armed,
  output logic        failsafe,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ARMED    = 2'd2,
    ST_FAILSAFE = 2'd3
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  ARM_TARGET   = 8'(ARM_FRAMES);
  localparam bit          ARM_ONE      = (ARM_FRAMES == 1);

  // ---------------------------------------------------------------------------
  // frame_done synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       edge_reg;
  logic       accept;
  logic       frame_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], frame_done};
      edge_reg <= sync_reg[1];
    end
  end

  // Single-cycle acceptance strobe; holding frame_done high gives one strobe.
  assign accept     = sync_reg[1] & ~edge_reg;
  assign frame_zero = (frame_data == 32'd0);

  // ---------------------------------------------------------------------------
  // Frame-loss timer (saturating)
  // ---------------------------------------------------------------------------
  state_t      state_reg, state_next;
  logic [31:0] timer_reg, timer_next;
  logic        expire;

  assign expire = (timer_reg == TIMEOUT_LAST);

  always_comb begin
    timer_next = timer_reg;
    if (accept || state_reg == ST_DISARMED) begin
      timer_next = 32'd0;
    end else if (timer_reg != 32'hFFFF_FFFF) begin
      timer_next = timer_reg + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Arming / failsafe state machine
  // ---------------------------------------------------------------------------
  logic [7:0]  zero_cnt_reg, zero_cnt_next;
  logic [31:0] target_reg, target_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_DISARMED;
      zero_cnt_reg <= 8'd0;
      target_reg   <= 32'd0;
      timer_reg    <= 32'd0;
    end else begin
      state_reg    <= state_next;
      zero_cnt_reg <= zero_cnt_next;
      target_reg   <= target_next;
      timer_reg    <= timer_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    zero_cnt_next = zero_cnt_reg;
    target_next   = target_reg;
    case (state_reg)
      // FAILSAFE recovers exactly like DISARMED: the first zero frame counts
      // as frame one of a fresh arming sequence.
      ST_DISARMED, ST_FAILSAFE: begin
        if (accept && frame_zero) begin
          target_next = 32'd0;
          if (ARM_ONE) begin
            state_next    = ST_ARMED;
            zero_cnt_next = 8'd0;
          end else begin
            state_next    = ST_ARMING;
            zero_cnt_next = 8'd1;
          end
        end
      end
      ST_ARMING: begin
        if (accept) begin
          if (frame_zero) begin
            if (zero_cnt_reg + 8'd1 >= ARM_TARGET) begin
              state_next    = ST_ARMED;
              zero_cnt_next = 8'd0;
              target_next   = 32'd0;
            end else begin
              zero_cnt_next = zero_cnt_reg + 8'd1;
            end
          end else begin
            state_next    = ST_DISARMED;
            zero_cnt_next = 8'd0;
          end
        end else if (expire) begin
          state_next    = ST_DISARMED;
          zero_cnt_next = 8'd0;
        end
      end
      ST_ARMED: begin
        // A frame arriving on the expiry cycle wins over the timer.
        if (accept) begin
          target_next = frame_data;
        end else if (expire) begin
          state_next  = ST_FAILSAFE;
          target_next = 32'd0;
        end
      end
      default: begin
        state_next    = ST_DISARMED;
        zero_cnt_next = 8'd0;
        target_next   = 32'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slew tick generator
  // ---------------------------------------------------------------------------
`ifdef MOTOR_CMD_SLEW_EN
  localparam logic [31:0] SLEW_LAST = 32'(SLEW_DIV - 1);

  logic [31:0] slew_cnt_reg, slew_cnt_next;
  logic        slew_tick;

  assign slew_tick = (slew_cnt_reg == SLEW_LAST);

  // Restart the tick phase on ARMED entry so ramps start from a known phase.
  always_comb begin
    slew_cnt_next = slew_cnt_reg + 32'd1;
    if ((state_next == ST_ARMED && state_reg != ST_ARMED) || slew_tick) begin
      slew_cnt_next = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slew_cnt_reg <= 32'd0;
    end else begin
      slew_cnt_reg <= slew_cnt_next;
    end
  end
`else
  logic unused_slew_div;
  assign unused_slew_div = ^SLEW_DIV;
`endif

  // ---------------------------------------------------------------------------
  // Per-byte command output
  // ---------------------------------------------------------------------------
  logic [31:0] motor_cmd_reg, motor_cmd_next;
  logic        drive_en;

  // Outputs are forced to zero on the same edge the FSM leaves ARMED.
  assign drive_en = (state_next == ST_ARMED);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      logic [7:0] cur;
      logic [7:0] tgt;
      logic [7:0] nxt;

      assign cur = motor_cmd_reg[gi*8 +: 8];
      assign tgt = target_reg[gi*8 +: 8];

`ifdef MOTOR_CMD_SLEW_EN
      // cur < tgt <= 0xFF here, so cur + 1 cannot wrap or overshoot.
      assign nxt = (tgt < cur)               ? tgt :
                   ((tgt > cur) && slew_tick) ? cur + 8'd1 :
                                                cur;
`else
      assign nxt = tgt;
`endif

      assign motor_cmd_next[gi*8 +: 8] = drive_en ? nxt : 8'd0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      motor_cmd_reg <= 32'd0;
    end else begin
      motor_cmd_reg <= motor_cmd_next;
    end
  end

  assign motor_cmd = motor_cmd_reg;
  assign state     = state_reg;
  assign armed     = (state_reg == ST_ARMED);
  assign failsafe  = (state_reg == ST_FAILSAFE);

endmodule

// File: tb/tb_motor_cmd_guard.sv
`timescale 1ns/1ps
module tb_motor_cmd_guard;

  localparam int unsigned TO = 1000;
  localparam int unsigned AF = 4;
  localparam int unsigned SD = 10;

`ifdef MOTOR_CMD_SLEW_EN
  localparam bit RISE_CHK = 1'b0;
`else
  localparam bit RISE_CHK = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_done = 1'b0;
  logic [31:0] frame_data = 32'd0;
  logic [31:0] motor_cmd;
  logic        armed;
  logic        failsafe;
  logic [1:0]  state;

  always #5 clk = ~clk;

  motor_cmd_guard #(
    .TIMEOUT_CYCLES(TO),
    .ARM_FRAMES(AF),
    .SLEW_DIV(SD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_done(frame_done),
    .frame_data(frame_data),
    .motor_cmd(motor_cmd),
    .armed(armed),
    .failsafe(failsafe),
    .state(state)
  );

  typedef struct {
    logic [1:0]  st;
    logic [31:0] cmd;
    bit          chk_cmd;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] cur_cmd = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one frame; expected result is pushed now and popped after edge 4.
  task automatic send_frame(input logic [31:0] d, input logic [1:0] st,
                            input bit chk_cmd, input int gap);
    exp_t e;
    @(negedge clk);
    frame_data = d;
    frame_done = 1'b1;
    e.st      = st;
    e.cmd     = (st == 2'd2) ? d : 32'd0;
    e.chk_cmd = chk_cmd;
    exp_q.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    check("state_edge3", {30'd0, state}, {30'd0, st});
    check("cmd_edge3", motor_cmd, cur_cmd);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state_edge4", {30'd0, state}, {30'd0, e.st});
    check("armed_edge4", {31'd0, armed}, {31'd0, (e.st == 2'd2)});
    check("failsafe_edge4", {31'd0, failsafe}, {31'd0, (e.st == 2'd3)});
    if (e.chk_cmd) check("cmd_edge4", motor_cmd, e.cmd);
    $display("[TB] frame %h -> state=%0d cmd=%h", d, state, motor_cmd);
    cur_cmd    = e.cmd;
    frame_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_cmd", motor_cmd, 32'd0);
    check("rst_armed", {31'd0, armed}, 32'd0);
    check("rst_failsafe", {31'd0, failsafe}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    // Arming: four zero frames 50 cycles apart
    send_frame(32'd0, 2'd1, 1'b1, 46);
    send_frame(32'd0, 2'd1, 1'b1, 46);
    send_frame(32'd0, 2'd1, 1'b1, 46);
    send_frame(32'd0, 2'd2, 1'b1, 46);

`ifdef MOTOR_CMD_SLEW_EN
    // Slewed ramp from 0 to 5, then immediate decrease
    begin
      logic [31:0] last;
      int          last_t;
      send_frame(32'h05050505, 2'd2, 1'b0, 0);
      last   = 32'd0;
      last_t = -1;
      for (int c = 0; c < 80; c++) begin
        if (motor_cmd !== last) begin
          check("slew_step", motor_cmd, last + 32'h01010101);
          if (last_t >= 0) check("slew_period", 32'(c - last_t), SD);
          last_t = c;
          last   = motor_cmd;
        end
        if (motor_cmd === 32'h05050505) break;
        @(posedge clk);
        #1;
      end
      check("slew_final", motor_cmd, 32'h05050505);
      send_frame(32'h02020202, 2'd2, 1'b1, 20);
    end
`else
    send_frame(32'h80FF0001, 2'd2, RISE_CHK, 20);
    send_frame(32'h00000000, 2'd2, 1'b1, 20);
`endif

    // Failsafe after TO cycles without a frame
    send_frame(32'h40404040, 2'd2, RISE_CHK, 0);
    repeat (998) @(posedge clk);
    #1;
    check("pre_expiry_state", {30'd0, state}, 32'd2);
    check("pre_expiry_cmd", motor_cmd, 32'h40404040);
    @(posedge clk);
    #1;
    check("expiry_state", {30'd0, state}, 32'd3);
    check("expiry_failsafe", {31'd0, failsafe}, 32'd1);
    check("expiry_armed", {31'd0, armed}, 32'd0);
    check("expiry_cmd", motor_cmd, 32'd0);
    $display("[TB] timeout -> state=%0d cmd=%h", state, motor_cmd);
    cur_cmd = 32'd0;

    // Nonzero frame ignored in FAILSAFE; zero frame restarts arming
    send_frame(32'h12345678, 2'd3, 1'b1, 10);
    send_frame(32'd0, 2'd1, 1'b1, 10);

    // Abort arming after two zero frames
    send_frame(32'd0, 2'd1, 1'b1, 10);
    send_frame(32'h10203040, 2'd0, 1'b1, 10);

    // frame_done held high for 200 cycles: exactly one acceptance
    @(negedge clk);
    frame_data = 32'd0;
    frame_done = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("hold_state", {30'd0, state}, 32'd1);
    $display("[TB] held frame -> state=%0d", state);
    frame_done = 1'b0;
    repeat (10) @(posedge clk);
    send_frame(32'd0, 2'd1, 1'b1, 10);
    send_frame(32'd0, 2'd1, 1'b1, 10);
    send_frame(32'd0, 2'd2, 1'b1, 10);

    // Frame accepted on the expiry cycle keeps ARMED
    send_frame(32'h20202020, 2'd2, RISE_CHK, 0);
    repeat (996) @(posedge clk);
    send_frame(32'h30303030, 2'd2, RISE_CHK, 5);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_cmd", motor_cmd, 32'd0);
    check("async_rst_state", {30'd0, state}, 32'd0);
    check("async_rst_armed", {31'd0, armed}, 32'd0);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_state", {30'd0, state}, 32'd0);
    check("post_rst_cmd", motor_cmd, 32'd0);
    $display("[TB] reset -> state=%0d cmd=%h", state, motor_cmd);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/motor_cmd_guard.md
# motor_cmd_guard

Safety stage between the SPI frame receiver and the four ESC pulse generators. It accepts each 32-bit throttle frame ({front, left, right, back}, 8 bits each) when the receiver's frame-complete level rises. It enforces an arming sequence and a frame-loss failsafe. It optionally rate-limits throttle increases before driving the per-motor 8-bit commands consumed by the ESC stage.

## Interface
- TIMEOUT_CYCLES, 4_000_000: clk cycles without an accepted frame before failsafe (100 ms at 40 MHz); width 32.
- ARM_FRAMES, 8: consecutive all-zero frames required to arm; 1..255.
- SLEW_DIV, 40_000: clk cycles per slew tick (1 ms at 40 MHz); width 32.

- clk  in  1  40 MHz system clock.
- reset  in  1  asynchronous, active-low; clears all state.
- frame_done  in  1  receiver frame-complete level, sck domain, asynchronous to clk.
- frame_data  in  32  {f1,f2,f3,f4}, MSB byte = front; stable while frame_done high.
- motor_cmd  out  32  guarded commands, same byte order.
- armed  out  1  high in ARMED.
- failsafe  out  1  high in FAILSAFE.
- state  out  2  DISARMED=0, ARMING=1, ARMED=2, FAILSAFE=3.

## Operation
- frame_done passes through a 2-flop synchronizer followed by a rising-edge detector.
- A frame is accepted on the single clk cycle the synchronized level rises; frame_data is sampled that cycle. Holding frame_done high yields exactly one acceptance.
- zero frame = all four bytes 0x00.
- Loss timer: 32-bit up-counter, cleared on every accepted frame and in DISARMED. It saturates; it expires when count == TIMEOUT_CYCLES-1.
- State machine:
  - DISARMED: motor_cmd = 0. Zero frame → ARMING with zero_cnt = 1; if ARM_FRAMES == 1, go to ARMED instead. Nonzero frames are ignored.
  - ARMING: motor_cmd = 0. Zero frame increments zero_cnt; when it reaches ARM_FRAMES → ARMED with targets 0. Nonzero frame → DISARMED, zero_cnt cleared. Timer expiry → DISARMED.
  - ARMED: each accepted frame loads the four target bytes; motor_cmd tracks the targets (see Configuration). Timer expiry → FAILSAFE.
  - FAILSAFE: targets and motor_cmd forced to 0 the cycle of entry. Nonzero frames are ignored. Zero frame → ARMING with zero_cnt = 1.
- Decreases in ARMED are never rate-limited: when a target is below the current output, that byte takes the target on the next cycle.
- Frame acceptance and timer expiry in the same cycle: the frame wins and the timer clears.
- Per-byte arithmetic is unsigned 8-bit. Increments clamp to the target and never wrap past 0xFF.

## Timing
- Reset values: motor_cmd = 0, armed = 0, failsafe = 0, state = 0, zero_cnt = 0, timers = 0, synchronizer flops = 0.
- Latency from the first clk edge sampling frame_done high:
  - acceptance on edge 3;
  - state/target update visible after edge 3;
  - motor_cmd update visible after edge 4.
- Failsafe entry: state = 3 and motor_cmd = 0 both visible after the expiry edge.
- Slew tick: a single-cycle pulse every SLEW_DIV cycles from a free-running counter. The counter restarts at 0 on entry to ARMED.
- Reset asserted mid-operation: all outputs zero immediately (asynchronously); the block restarts in DISARMED.

## Configuration
- MOTOR_CMD_SLEW_EN defined: in ARMED, each byte rises by at most 1 per slew tick toward its target; decreases remain immediate.
- MOTOR_CMD_SLEW_EN undefined: the slew counter is removed; in ARMED, motor_cmd equals the targets one cycle after acceptance in both directions.

## Test plan
All scenarios use TIMEOUT_CYCLES=1000, ARM_FRAMES=4, SLEW_DIV=10.
- Arming: 4 zero frames 50 cycles apart → state 1 after frame 1, state 2 and armed=1 after frame 4; motor_cmd = 0 throughout.
- Abort arming: 2 zero frames, then 0x10203040 → state returns to 0 and zero_cnt is cleared; 4 further zero frames are needed to arm.
- Armed, slew undefined: frame 0x80FF0001 → motor_cmd = 0x80FF0001 four cycles after frame_done rises; then 0x00000000 → motor_cmd = 0 after four cycles.
- Armed, MOTOR_CMD_SLEW_EN defined: frame 0x05050505 from 0 → motor_cmd steps 0x01010101 … 0x05050505 on five successive slew ticks (50 cycles); then 0x02020202 → motor_cmd = 0x02020202 next cycle.
- Failsafe: armed at 0x40404040 with no frames for 1000 cycles → state 3, failsafe=1, motor_cmd = 0. Then a nonzero frame → no change; then a zero frame → state 1.
- Edge cases:
  - frame_done held high for 200 cycles → exactly one acceptance;
  - frame arriving on the expiry cycle → no failsafe;
  - reset low mid-slew → motor_cmd = 0 and state = 0 without waiting for a clk edge.
